sequential_window_median: RTL and testbench
===========================================

Name: sequential_window_median

Overview:
Streaming 3x3 rank filter for the image pipeline. Accepts one 3-pixel column (rows A/B/C) per valid cycle and keeps a sliding window of the last three columns. Outputs the window's median, minimum or maximum through a fixed 3-stage pipeline. Generalises the fixed 8-bit, free-running nine-median with parametrised pixel width, valid qualification, line restart, warm-up suppression and selectable rank mode.

Parameters:
WIDTH, 8, pixel bit width (1..16).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A_in  input  WIDTH  column pixel, top row
B_in  input  WIDTH  column pixel, middle row
C_in  input  WIDTH  column pixel, bottom row
valid_in  input  1  column on A/B/C_in is valid this cycle
sol_in  input  1  start of line, qualified by valid_in
mode_in  input  2  00 median, 01 min, 10 max, 11 treated as median; sampled with valid_in
median_out  output  WIDTH  selected rank value of the window
valid_out  output  1  median_out is new this cycle (one-cycle pulse per result)

Behaviour:
- Reset (async assert, sync-safe deassert): window registers, column count, pipeline data, median_out = 0, valid_out = 0, captured modes = 00.
- Stage 0 (edge where valid_in=1): the incoming column is sorted (lo<=mid<=hi) and shifted into window slot 2. Slots 2->1->0 shift. Column count increments, saturating at 3. If sol_in=1, count is forced to 1 and older slots are don't-care. win_ok = (count after update == 3). mode_in is captured alongside.
- valid_in=0: window, count and stage-0 state hold. No result is generated (bubble). sol_in and mode_in are ignored.
- Stage 1 (next edge): from the three sorted columns, register max_lo = max of lows, med_mid = median of mids, min_hi = min of highs, min_all = min of lows, max_all = max of highs. valid and mode propagate.
- Stage 2 (next edge): median_out = median3(max_lo, med_mid, min_hi) for mode 00/11, min_all for 01, max_all for 10. valid_out = stage-1 valid. When valid_out=0, median_out holds its previous value.
- Latency: the column accepted at edge N produces valid_out=1 in the cycle after edge N+2, provided win_ok at edge N.
- Throughput: one result per valid column once warm. Back-to-back columns never stall.
- Warm-up: the first two columns after reset or after sol_in produce no valid_out.
- sol_in on consecutive valid columns keeps count at 1, so there is no output.
- Mode may change on every column. Each result uses the mode captured with its own column.
- All comparisons are unsigned, WIDTH bits. Equal values are allowed and no widening is needed.
- Reset mid-stream: in-flight results are discarded and warm-up restarts.

Decomposition:
- Package sequential_median_pkg: mode constants MODE_MEDIAN=2'b00, MODE_MIN=2'b01, MODE_MAX=2'b10, and the window depth constant WIN_COLS=3.
- One combinational sub-module sort3 (WIDTH parametrised; outputs lo/mid/hi). It is reused for column sort, the mid-median and the final median3.
- Min/max of three are done inline.

Test Plan:
1. WIDTH=8, mode 00, columns (0,1,2),(3,4,5),(6,7,8) on consecutive cycles -> no valid_out for the first two. valid_out=1 with median_out=4 two cycles after the third column. Next column (0,1,2) -> median_out=4 again one cycle later.
2. Unsorted columns (9,2,7),(200,1,5),(3,3,255), mode 00 -> median_out=5. Same window with mode 01 -> 1. Same window with mode 10 -> 255.
3. Bubbles: three valid columns separated by 2 idle cycles each -> exactly one valid_out pulse, value equal to the back-to-back case. median_out is stable while valid_out=0.
4. sol_in with 4th column of a warm stream -> no valid_out for that column or the next. The third column after sol_in yields a median computed only from post-sol columns.
5. WIDTH=12: all nine pixels 4095 except one 0 -> median 4095, min 0, max 4095. Per-column mode switching 00,01,10 on a warm stream -> each result matches its own mode.
6. rst_n pulsed low mid-stream while results are in flight -> valid_out and median_out drop to 0 asynchronously. No stale pulse after release. Two-column warm-up is required again.

Source files
------------

// File: rtl/sequential_median_pkg.sv
// Shared constants for the 3x3 sliding-window rank filter: rank-mode
// encodings and the window depth in columns.
package sequential_median_pkg;
  localparam logic [1:0] MODE_MEDIAN = 2'b00;
  localparam logic [1:0] MODE_MIN    = 2'b01;
  localparam logic [1:0] MODE_MAX    = 2'b10;
  localparam int         WIN_COLS    = 3;
endpackage

// File: rtl/sequential_window_median_sort3.sv
// Combinational three-input sorter (lo <= mid <= hi, unsigned), built from a
// three compare-exchange network.
module sort3 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mid,
  output logic [WIDTH-1:0] hi
);
  logic [WIDTH-1:0] ab_lo, ab_hi, x_lo;

  assign ab_lo = (a < b) ? a : b;
  assign ab_hi = (a < b) ? b : a;
  // The larger of a/b meets c; its loser then meets the smaller of a/b.
  assign x_lo  = (ab_hi < c) ? ab_hi : c;
  assign hi    = (ab_hi < c) ? c : ab_hi;
  assign lo    = (ab_lo < x_lo) ? ab_lo : x_lo;
  assign mid   = (ab_lo < x_lo) ? x_lo : ab_lo;
endmodule

// File: rtl/sequential_window_median.sv
// Streaming 3x3 rank filter: sorts each incoming column, keeps the last three
// columns, and returns median/min/max of the window after a 3-stage pipeline.
module sequential_window_median
  import sequential_median_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [WIDTH-1:0] C_in,
  input  logic             valid_in,
  input  logic             sol_in,
  input  logic [1:0]       mode_in,
  output logic [WIDTH-1:0] median_out,
  output logic             valid_out
);
  // Handshake: valid_in qualifies A/B/C_in, sol_in and mode_in in the same
  // cycle; there is no ready, every valid column is accepted. valid_out is a
  // one-cycle pulse per result and median_out holds between pulses.
  typedef logic [WIDTH-1:0] pix_t;
  localparam logic [1:0] CNT_FULL = 2'(WIN_COLS);

  function automatic pix_t min2(input pix_t x, input pix_t y);
    return (x < y) ? x : y;
  endfunction

  function automatic pix_t max2(input pix_t x, input pix_t y);
    return (x < y) ? y : x;
  endfunction

  pix_t col_lo, col_mid, col_hi;
  sort3 #(.WIDTH(WIDTH)) u_col_sort (
    .a(A_in), .b(B_in), .c(C_in), .lo(col_lo), .mid(col_mid), .hi(col_hi)
  );

  // Stage 0: window of sorted columns, slot WIN_COLS-1 is the newest.
  pix_t       win_lo_q [WIN_COLS], win_lo_d [WIN_COLS];
  pix_t       win_mid_q[WIN_COLS], win_mid_d[WIN_COLS];
  pix_t       win_hi_q [WIN_COLS], win_hi_d [WIN_COLS];
  logic [1:0] cnt_q, cnt_d;
  logic       s0_valid_q, s0_valid_d;
  logic [1:0] s0_mode_q, s0_mode_d;

  always_comb begin
    win_lo_d   = win_lo_q;
    win_mid_d  = win_mid_q;
    win_hi_d   = win_hi_q;
    cnt_d      = cnt_q;
    s0_valid_d = 1'b0;
    s0_mode_d  = s0_mode_q;
    if (valid_in) begin
      for (int i = 0; i < WIN_COLS - 1; i++) begin
        win_lo_d[i]  = win_lo_q[i+1];
        win_mid_d[i] = win_mid_q[i+1];
        win_hi_d[i]  = win_hi_q[i+1];
      end
      win_lo_d[WIN_COLS-1]  = col_lo;
      win_mid_d[WIN_COLS-1] = col_mid;
      win_hi_d[WIN_COLS-1]  = col_hi;
      // Line start leaves older slots stale; the count keeps them out.
      if (sol_in)                 cnt_d = 2'd1;
      else if (cnt_q != CNT_FULL) cnt_d = cnt_q + 2'd1;
      s0_valid_d = (cnt_d == CNT_FULL);
      s0_mode_d  = mode_in;
    end
  end

  // Stage 1: partial ranks across the three sorted columns.
  pix_t       med_mid, mid_sort_lo, mid_sort_hi;
  pix_t       max_lo_q, max_lo_d, med_mid_q, med_mid_d, min_hi_q, min_hi_d;
  pix_t       min_all_q, min_all_d, max_all_q, max_all_d;
  logic       s1_valid_q, s1_valid_d;
  logic [1:0] s1_mode_q, s1_mode_d;

  sort3 #(.WIDTH(WIDTH)) u_mid_sort (
    .a(win_mid_q[0]), .b(win_mid_q[1]), .c(win_mid_q[2]),
    .lo(mid_sort_lo), .mid(med_mid), .hi(mid_sort_hi)
  );

  always_comb begin
    max_lo_d   = max2(max2(win_lo_q[0], win_lo_q[1]), win_lo_q[2]);
    med_mid_d  = med_mid;
    min_hi_d   = min2(min2(win_hi_q[0], win_hi_q[1]), win_hi_q[2]);
    min_all_d  = min2(min2(win_lo_q[0], win_lo_q[1]), win_lo_q[2]);
    max_all_d  = max2(max2(win_hi_q[0], win_hi_q[1]), win_hi_q[2]);
    s1_valid_d = s0_valid_q;
    s1_mode_d  = s0_mode_q;
  end

  // Stage 2: final rank selection.
  pix_t fin_lo, fin_mid, fin_hi;
  pix_t median_q, median_d;
  logic valid_q, valid_d;
  logic unused_sort;

  sort3 #(.WIDTH(WIDTH)) u_fin_sort (
    .a(max_lo_q), .b(med_mid_q), .c(min_hi_q),
    .lo(fin_lo), .mid(fin_mid), .hi(fin_hi)
  );
  assign unused_sort = ^{mid_sort_lo, mid_sort_hi, fin_lo, fin_hi};

  always_comb begin
    median_d = median_q;
    valid_d  = s1_valid_q;
    if (s1_valid_q) begin
      case (s1_mode_q)
        MODE_MIN: median_d = min_all_q;
        MODE_MAX: median_d = max_all_q;
        default:  median_d = fin_mid;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_COLS; i++) begin
        win_lo_q[i]  <= '0;
        win_mid_q[i] <= '0;
        win_hi_q[i]  <= '0;
      end
      cnt_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_mode_q  <= MODE_MEDIAN;
      max_lo_q   <= '0;
      med_mid_q  <= '0;
      min_hi_q   <= '0;
      min_all_q  <= '0;
      max_all_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_MEDIAN;
      median_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      win_lo_q   <= win_lo_d;
      win_mid_q  <= win_mid_d;
      win_hi_q   <= win_hi_d;
      cnt_q      <= cnt_d;
      s0_valid_q <= s0_valid_d;
      s0_mode_q  <= s0_mode_d;
      max_lo_q   <= max_lo_d;
      med_mid_q  <= med_mid_d;
      min_hi_q   <= min_hi_d;
      min_all_q  <= min_all_d;
      max_all_q  <= max_all_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      median_q   <= median_d;
      valid_q    <= valid_d;
    end
  end

  assign median_out = median_q;
  assign valid_out  = valid_q;
endmodule

// File: tb/tb_sequential_window_median.sv
// Directed bench for sequential_window_median: an 8-bit and a 12-bit instance
// driven with hand-computed columns; each step is one clock, outputs sampled 1ns after the edge.
module tb_sequential_window_median;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0, c8 = '0, med8;
  logic        v8 = 1'b0, sol8 = 1'b0, vo8;
  logic [1:0]  m8 = 2'b00;
  logic [11:0] a12 = '0, b12 = '0, c12 = '0, med12;
  logic        v12 = 1'b0, sol12 = 1'b0, vo12;
  logic [1:0]  m12 = 2'b00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequential_window_median #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A_in(a8), .B_in(b8), .C_in(c8),
    .valid_in(v8), .sol_in(sol8), .mode_in(m8),
    .median_out(med8), .valid_out(vo8)
  );

  sequential_window_median #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .A_in(a12), .B_in(b12), .C_in(c12),
    .valid_in(v12), .sol_in(sol12), .mode_in(m12),
    .median_out(med12), .valid_out(vo12)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ck8(input string tag, input logic ev, input logic [7:0] em);
    chk({tag, "_v8"}, 16'(vo8), 16'(ev));
    chk({tag, "_d8"}, 16'(med8), 16'(em));
  endtask

  task automatic ck12(input string tag, input logic ev, input logic [11:0] em);
    chk({tag, "_v12"}, 16'(vo12), 16'(ev));
    chk({tag, "_d12"}, 16'(med12), 16'(em));
  endtask

  task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic v, input logic sol, input logic [1:0] m);
    a8 = a; b8 = b; c8 = c; v8 = v; sol8 = sol; m8 = m;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with sol/mode deliberately asserted: they must be ignored.
  task automatic idle8();
    step8(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 2'b10);
  endtask

  task automatic step12(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                        input logic v, input logic sol, input logic [1:0] m);
    a12 = a; b12 = b; c12 = c; v12 = v; sol12 = sol; m12 = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    ck8("rst", 1'b0, 8'd0);
    ck12("rst", 1'b0, 12'd0);
    rst_n = 1'b1;

    // back-to-back warm-up and first result
    step8(0, 1, 2, 1, 0, 2'b00);   ck8("t1_c0", 0, 0);
    step8(3, 4, 5, 1, 0, 2'b00);   ck8("t1_c1", 0, 0);
    step8(6, 7, 8, 1, 0, 2'b00);   ck8("t1_c2", 0, 0);
    step8(0, 1, 2, 1, 0, 2'b00);   ck8("t1_c3", 0, 0);
    idle8();                        ck8("t1_r2", 1, 4);
    idle8();                        ck8("t1_r3", 1, 4);
    idle8();                        ck8("t1_hold", 0, 4);

    // unsorted columns, per-column mode switching on a repeating window
    step8(9, 2, 7, 1, 1, 2'b00);   ck8("t2_c0", 0, 4);
    step8(200, 1, 5, 1, 0, 2'b00); ck8("t2_c1", 0, 4);
    step8(3, 3, 255, 1, 0, 2'b00); ck8("t2_c2", 0, 4);
    step8(9, 2, 7, 1, 0, 2'b01);   ck8("t2_c3", 0, 4);
    step8(200, 1, 5, 1, 0, 2'b10); ck8("t2_med", 1, 5);
    step8(3, 3, 255, 1, 0, 2'b11); ck8("t2_min", 1, 1);
    idle8();                        ck8("t2_max", 1, 255);
    idle8();                        ck8("t2_m11", 1, 5);
    idle8();                        ck8("t2_hold", 0, 5);

    // bubbles between columns
    step8(9, 2, 7, 1, 1, 2'b00);   ck8("t3_c0", 0, 5);
    idle8();                        ck8("t3_b0", 0, 5);
    idle8();                        ck8("t3_b1", 0, 5);
    step8(200, 1, 5, 1, 0, 2'b00); ck8("t3_c1", 0, 5);
    idle8();                        ck8("t3_b2", 0, 5);
    idle8();                        ck8("t3_b3", 0, 5);
    step8(3, 3, 255, 1, 0, 2'b01); ck8("t3_c2", 0, 5);
    idle8();                        ck8("t3_b4", 0, 5);
    idle8();                        ck8("t3_res", 1, 1);
    idle8();                        ck8("t3_hold0", 0, 1);
    idle8();                        ck8("t3_hold1", 0, 1);

    // line restart on the fourth column of a warm stream
    step8(0, 1, 2, 1, 1, 2'b00);    ck8("t4_c0", 0, 1);
    step8(3, 4, 5, 1, 0, 2'b00);    ck8("t4_c1", 0, 1);
    step8(6, 7, 8, 1, 0, 2'b00);    ck8("t4_c2", 0, 1);
    step8(12, 50, 3, 1, 1, 2'b00);  ck8("t4_sol", 0, 1);
    step8(40, 41, 2, 1, 0, 2'b00);  ck8("t4_pre", 1, 4);
    step8(100, 7, 60, 1, 0, 2'b00); ck8("t4_w0", 0, 4);
    idle8();                         ck8("t4_w1", 0, 4);
    idle8();                         ck8("t4_res", 1, 40);
    idle8();                         ck8("t4_hold", 0, 40);

    // sol on consecutive columns never warms up
    step8(1, 2, 3, 1, 1, 2'b00);   ck8("t4s_0", 0, 40);
    step8(4, 5, 6, 1, 1, 2'b00);   ck8("t4s_1", 0, 40);
    step8(7, 8, 9, 1, 1, 2'b00);   ck8("t4s_2", 0, 40);
    idle8();                        ck8("t4s_3", 0, 40);
    idle8();                        ck8("t4s_4", 0, 40);
    idle8();                        ck8("t4s_5", 0, 40);

    // asynchronous reset with results in flight
    step8(9, 2, 7, 1, 1, 2'b00);   ck8("t6_c0", 0, 40);
    step8(200, 1, 5, 1, 0, 2'b00); ck8("t6_c1", 0, 40);
    step8(3, 3, 255, 1, 0, 2'b00); ck8("t6_c2", 0, 40);
    step8(9, 2, 7, 1, 0, 2'b00);   ck8("t6_c3", 0, 40);
    step8(200, 1, 5, 1, 0, 2'b00); ck8("t6_pre", 1, 5);
    #2 rst_n = 1'b0;
    #1 ck8("t6_async", 0, 0);
    @(posedge clk);
    #1 ck8("t6_inrst", 0, 0);
    rst_n = 1'b1;
    idle8();                        ck8("t6_s0", 0, 0);
    idle8();                        ck8("t6_s1", 0, 0);
    idle8();                        ck8("t6_s2", 0, 0);
    step8(9, 2, 7, 1, 0, 2'b00);   ck8("t6_w0", 0, 0);
    step8(200, 1, 5, 1, 0, 2'b00); ck8("t6_w1", 0, 0);
    step8(3, 3, 255, 1, 0, 2'b00); ck8("t6_w2", 0, 0);
    idle8();                        ck8("t6_w3", 0, 0);
    idle8();                        ck8("t6_res", 1, 5);
    idle8();                        ck8("t6_hold", 0, 5);

    // 12-bit instance: single zero among 4095s, modes 00/01/10
    step12(4095, 4095, 4095, 1, 1, 2'b00); ck12("t5_c0", 0, 0);
    step12(4095, 0, 4095, 1, 0, 2'b00);    ck12("t5_c1", 0, 0);
    step12(4095, 4095, 4095, 1, 0, 2'b00); ck12("t5_c2", 0, 0);
    step12(4095, 4095, 4095, 1, 0, 2'b01); ck12("t5_c3", 0, 0);
    step12(4095, 0, 4095, 1, 0, 2'b10);    ck12("t5_med", 1, 4095);
    step12(0, 0, 0, 0, 0, 2'b00);          ck12("t5_min", 1, 0);
    step12(0, 0, 0, 0, 0, 2'b00);          ck12("t5_max", 1, 4095);
    step12(0, 0, 0, 0, 0, 2'b00);          ck12("t5_hold", 0, 4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
